vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
- Parametrised successor to the fixed-mode VGA driver.
- Generates programmable H/V sync timing, DAC blank and pixel clock.
- Fetches pixels for an image window from an external frame buffer over a 1-cycle-latency read port. Pixels outside the window are filled from a built-in test-pattern generator.
- Sits between the pixel PLL output and the ADV-style VGA DAC; the frame buffer or line store attaches to the read port.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- RGB_W, 16, pixel width (RGB565 at 16)
- WIN_X0, 0, window left column
- WIN_Y0, 0, window top line
- WIN_W, 640, window width
- WIN_H, 480, window height
- ADDR_W, 19, width of rd_addr

Ports:
- clk  in  1  pixel clock from PLL
- rst_n  in  1  synchronous active-low reset (sampled on clk rising edge)
- mode  in  2  fill select: 0 black, 1 colour bars, 2 grid, 3 solid `fill_rgb`
- fill_rgb  in  RGB_W  solid fill colour
- din  in  RGB_W  pixel data, valid 1 clk after rd_en
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  ADDR_W  linear window address
- rd_end  out  1  1-clk pulse with the last window read of a frame
- frame_start  out  1  1-clk pulse when h_cnt = 0 and v_cnt = 0
- vga_clk  out  1  ~clk; DAC samples mid-cycle
- vga_hys  out  1  horizontal sync
- vga_vys  out  1  vertical sync
- vga_blank_n  out  1  high in active area
- vga_rgb  out  RGB_W  pixel to DAC

Behaviour:
- Timing constants: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps; v_cnt wraps at V_TOTAL-1 to 0.
- Region order in both axes: active, front porch, sync, back porch.
- Active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync is asserted (at level SYNC_POL) for:
  - horizontal: H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vertical: V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC
- Pipeline, for counter position P at cycle t:
  - t+1: rd_en and rd_addr for P are registered.
  - t+2: din is sampled; vga_hys, vga_vys, vga_blank_n and vga_rgb for P are registered.
  - Fixed latency is therefore 2 clocks from counter to DAC pins, and all four video outputs stay mutually aligned.
- In-window test: WIN_X0 ≤ h < WIN_X0+WIN_W, WIN_Y0 ≤ v < WIN_Y0+WIN_H, intersected with the active area. Any window part beyond the active area is clipped and never read.
- rd_en = 1 only for in-window positions.
- rd_addr = 0 at the first window pixel, increments by 1 per rd_en, and resets to 0 at frame_start.
- rd_addr after reset is 0.
- rd_end pulses together with the rd_en for the final in-window pixel. It does not pulse if the window is fully clipped (WIN_X0 ≥ H_ACTIVE or WIN_Y0 ≥ V_ACTIVE).
- Pixel select at t+2:
  - blanked: vga_rgb = 0
  - in-window: vga_rgb = din
  - otherwise: the fill selected by the latched mode
- mode and fill_rgb are latched only on the cycle frame_start is asserted. A change mid-frame takes effect from the next frame, so no tearing.
- Colour bars: 8 vertical bars of equal width H_ACTIVE/8 (integer division; remainder columns use the last bar). Colours in order, per channel at full scale:
  - white, yellow, cyan, green, magenta, red, blue, black
- Grid: white when h_cnt[4:0] = 0 or v_cnt[4:0] = 0, else black.
- Reset (any cycle, including mid-frame) — on the next rising edge:
  - h_cnt = v_cnt = 0
  - rd_en = 0, rd_end = 0, frame_start = 0
  - sync outputs at inactive level (~SYNC_POL)
  - vga_blank_n = 0, vga_rgb = 0
  - latched mode = 0
- The first frame_start follows the first clock after rst_n is released.
- vga_clk is not reset; it is always ~clk.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN
- Defined: mode 1/2/3 fills behave as above.
- Undefined: the pattern logic is removed; mode and fill_rgb are ignored; every non-window active pixel outputs 0. Window fetch and timing are unchanged.

Test Plan:
- Small-timing sanity: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=0 → vga_hys low 3 clks per 15-clk line; vga_vys low for 15 clks every 105 clks; vga_blank_n high 8 clks on each of 4 lines; frame_start period 105.
- Window fetch: WIN_X0=2, WIN_Y0=1, WIN_W=4, WIN_H=2, bench returns din = rd_addr → rd_addr runs 0..7 over two lines; rd_end coincides with the 8th rd_en; vga_rgb shows 0..7 exactly 2 clks after the matching counter position.
- Clipping: WIN_X0=6, WIN_W=4 on H_ACTIVE=8 → only 2 reads per window line; rd_addr reaches 2·WIN_H−1 total; rd_end still pulses once.
- Mode latch: switch mode 1→3 with fill_rgb=16'hF800 mid-frame → current frame keeps bars; next frame's non-window pixels = F800.
- Reset mid-frame: drop rst_n at h_cnt=5, v_cnt=2 for 1 clk → next edge blank_n=0, rgb=0, syncs high, rd_en=0; after release, frame_start asserts and the full frame repeats from (0,0).
- Macro off: rebuild without VGA_TEST_PATTERN_EN, mode=3, fill_rgb=FFFF → all non-window active pixels = 0.

Source files
------------

// File: rtl/vga_timing_ctrl_if.sv
// Frame-buffer read port of vga_timing_ctrl: registered strobe/address out,
// pixel data back one clock later.
interface vga_timing_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int RGB_W  = 16
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_end;
  logic [RGB_W-1:0]  din;

  modport master (output rd_en, rd_addr, rd_end, input din);
  modport slave  (input rd_en, rd_addr, rd_end, output din);
endinterface

// File: rtl/vga_timing_ctrl.sv
// Programmable VGA timing generator with windowed frame-buffer fetch and fill.
// Define VGA_TEST_PATTERN_EN to enable the bars/grid/solid fill generator.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int RGB_W    = 16,
  parameter int WIN_X0   = 0,
  parameter int WIN_Y0   = 0,
  parameter int WIN_W    = 640,
  parameter int WIN_H    = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [RGB_W-1:0]  fill_rgb,
  vga_timing_ctrl_if.master fb,
  output logic              frame_start,
  output logic              vga_clk,
  output logic              vga_hys,
  output logic              vga_vys,
  output logic              vga_blank_n,
  output logic [RGB_W-1:0]  vga_rgb
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W     = ($clog2(H_TOTAL) < 5) ? 5 : $clog2(H_TOTAL);
  localparam int VC_W     = ($clog2(V_TOTAL) < 5) ? 5 : $clog2(V_TOTAL);
  localparam int H_SYNC_S = H_ACTIVE + H_FP;
  localparam int H_SYNC_E = H_SYNC_S + H_SYNC;
  localparam int V_SYNC_S = V_ACTIVE + V_FP;
  localparam int V_SYNC_E = V_SYNC_S + V_SYNC;
  // Window edges clipped to the active area; an empty range disables fetch.
  localparam int WIN_XE   = (WIN_X0 + WIN_W > H_ACTIVE) ? H_ACTIVE : WIN_X0 + WIN_W;
  localparam int WIN_YE   = (WIN_Y0 + WIN_H > V_ACTIVE) ? V_ACTIVE : WIN_Y0 + WIN_H;
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [HC_W-1:0]   h_cnt;
  logic [VC_W-1:0]   v_cnt;
  int                h_i, v_i;
  logic              at_origin, active, in_win, win_last, hs_on, vs_on;
  logic [ADDR_W-1:0] addr_cnt, addr_base;
  logic [RGB_W-1:0]  fill_pix;

  logic              rd_en_p1, rd_end_p1, active_p1, hs_p1, vs_p1;
  logic [ADDR_W-1:0] rd_addr_p1;
  logic [RGB_W-1:0]  fill_p1;

  assign vga_clk = ~clk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HC_W'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VC_W'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign h_i       = int'(h_cnt);
  assign v_i       = int'(v_cnt);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
  assign in_win    = (h_i >= WIN_X0) && (h_i < WIN_XE) && (v_i >= WIN_Y0) && (v_i < WIN_YE);
  assign win_last  = in_win && (h_i == WIN_XE - 1) && (v_i == WIN_YE - 1);
  assign hs_on     = (h_i >= H_SYNC_S) && (h_i < H_SYNC_E);
  assign vs_on     = (v_i >= V_SYNC_S) && (v_i < V_SYNC_E);
  assign addr_base = at_origin ? '0 : addr_cnt;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
  localparam int B_W   = RGB_W / 3;
  localparam int G_W   = RGB_W - 2 * B_W;
  // {r,g,b} full-scale flags: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_CODES = {3'b111, 3'b110, 3'b011, 3'b010,
                                       3'b101, 3'b100, 3'b001, 3'b000};

  logic [1:0]       mode_q, mode_sel;
  logic [RGB_W-1:0] fill_q, fill_sel;

  function automatic logic [RGB_W-1:0] bar_color(input int col);
    int         idx;
    logic [2:0] c;
    idx = col / BAR_W;
    if (idx > 7) idx = 7;
    c = BAR_CODES[(7 - idx) * 3 +: 3];
    return {{B_W{c[2]}}, {G_W{c[1]}}, {B_W{c[0]}}};
  endfunction

  function automatic logic [RGB_W-1:0] pattern_pix(input logic [1:0] m,
                                                   input logic [RGB_W-1:0] solid,
                                                   input int col,
                                                   input logic [4:0] h_lo,
                                                   input logic [4:0] v_lo);
    case (m)
      2'd0:    return '0;
      2'd1:    return bar_color(col);
      2'd2:    return (h_lo == 5'd0 || v_lo == 5'd0) ? {RGB_W{1'b1}} : {RGB_W{1'b0}};
      default: return solid;
    endcase
  endfunction

  // The origin pixel already uses the value being latched, so a frame never mixes modes.
  assign mode_sel = at_origin ? mode : mode_q;
  assign fill_sel = at_origin ? fill_rgb : fill_q;
  assign fill_pix = pattern_pix(mode_sel, fill_sel, h_i, h_cnt[4:0], v_cnt[4:0]);

  always_ff @(posedge clk) begin
    if (!rst_n)         mode_q <= 2'd0;
    else if (at_origin) mode_q <= mode;
  end

  always_ff @(posedge clk) begin
    if (at_origin) fill_q <= fill_rgb;
  end
`else
  logic unused_pattern_in;
  assign unused_pattern_in = ^{mode, fill_rgb};
  assign fill_pix = '0;
`endif

  // Stage p1: fetch request and per-position flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en_p1    <= 1'b0;
      rd_end_p1   <= 1'b0;
      rd_addr_p1  <= '0;
      addr_cnt    <= '0;
      frame_start <= 1'b0;
      active_p1   <= 1'b0;
      hs_p1       <= 1'b0;
      vs_p1       <= 1'b0;
    end else begin
      rd_en_p1    <= in_win;
      rd_end_p1   <= win_last;
      frame_start <= at_origin;
      active_p1   <= active;
      hs_p1       <= hs_on;
      vs_p1       <= vs_on;
      addr_cnt    <= in_win ? addr_base + 1'b1 : addr_base;
      if (in_win) rd_addr_p1 <= addr_base;
    end
  end

  always_ff @(posedge clk) begin
    fill_p1 <= fill_pix;
  end

  assign fb.rd_en   = rd_en_p1;
  assign fb.rd_end  = rd_end_p1;
  assign fb.rd_addr = rd_addr_p1;

  // Stage p2: DAC pins, fetched data merged with fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_hys     <= ~SYNC_ON;
      vga_vys     <= ~SYNC_ON;
      vga_blank_n <= 1'b0;
      vga_rgb     <= '0;
    end else begin
      vga_hys     <= hs_p1 ? SYNC_ON : ~SYNC_ON;
      vga_vys     <= vs_p1 ? SYNC_ON : ~SYNC_ON;
      vga_blank_n <= active_p1;
      vga_rgb     <= !active_p1 ? '0 : (rd_en_p1 ? fb.din : fill_p1);
    end
  end

endmodule
